// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the IF-stage fetch controller.
//   XLEN                - datapath width
//   RESET_ADDR_DEFAULT  - default first fetch address
//   NOP                 - instruction word presented to decode when nothing is valid
//   fetch_state_e       - controller FSM states
//   inst_entry_t        - instruction queue entry (word plus its PC)
//   word_align()        - clears addr[1:0] of a redirect target
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP                = 32'h0000_0013;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StFlush
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } inst_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: generic circular FIFO with synchronous clear.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clr_i          - empties the queue; wins over push/pop in the same cycle
//   push_i, data_i - write port (ignored when full unless a pop frees a slot)
//   pop_i, data_o  - read port, data_o shows the head entry
//   count_o        - current occupancy
//   empty_o        - occupancy is zero
module fetch_queue #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic [CntW-1:0]  count_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop) begin
                count_d = count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch controller.
// Owns the PC, issues req/gnt/rvalid fetches (at most BUF_DEPTH in flight plus
// queued), buffers returned words with their PCs toward decode and discards
// responses that were in flight when a redirect arrived.
//   clk, rst_n                  - clock, asynchronous active-low reset
//   imem_req_o/addr_o           - fetch request and word-aligned address
//   imem_gnt_i                  - request accepted this cycle
//   imem_rvalid_i/rdata_i       - in-order response
//   branch_flag/branch_addr     - execute-stage redirect (highest priority)
//   pred_flag/pred_addr         - predictor redirect, only with FETCH_PRED_EN
//   inst_valid_o/inst_o         - instruction toward decode
//   inst_addr_out               - PC of inst_o
//   inst_ready_i                - decode accepts (transfer on valid && ready)
// Build option: define FETCH_PRED_EN to add the predictor redirect ports.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter int unsigned     BUF_DEPTH  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            branch_flag,
    input  logic [XLEN-1:0] branch_addr,
`ifdef FETCH_PRED_EN
    input  logic            pred_flag,
    input  logic [XLEN-1:0] pred_addr,
`endif
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_out,
    input  logic            inst_ready_i
);

    localparam int unsigned CntW  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CntW1 = CntW + 1;
    localparam logic [CntW:0] DepthC = CntW1'(BUF_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CntW-1:0] discard_q, discard_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            grant;
    logic            inst_push, inst_pop;
    logic [CntW-1:0] out_cnt, occ_cnt;
    logic            addr_empty, inst_empty;
    logic [XLEN-1:0] addr_head;
    inst_entry_t     inst_in, inst_head;
    logic [CntW:0]   load, limit, stale_sum;

    always_comb begin
`ifdef FETCH_PRED_EN
        redirect = branch_flag || pred_flag;
        target   = branch_flag ? branch_addr : pred_addr;
`else
        redirect = branch_flag;
        target   = branch_addr;
`endif
    end

    assign grant = imem_req_o && imem_gnt_i;

    // Response belongs to a live request: not being flushed, not in a redirect
    // cycle, and matched by a tagged address (late responses after reset drop).
    assign inst_push    = imem_rvalid_i && (discard_q == '0) && !redirect && !addr_empty;
    assign inst_valid_o = !inst_empty;
    assign inst_pop     = inst_valid_o && inst_ready_i;

    // A pop this cycle frees a slot, so a full queue can still issue.
    assign load  = {1'b0, out_cnt} + {1'b0, occ_cnt};
    assign limit = DepthC + {{CntW{1'b0}}, inst_pop};

    // In-flight responses to drop after a redirect: tagged ones, plus one
    // granted now, minus one returning now.
    always_comb begin
        stale_sum = {1'b0, out_cnt} + {{CntW{1'b0}}, grant};
        if (imem_rvalid_i && (stale_sum != '0)) begin
            stale_sum = stale_sum - CntW1'(1);
        end
    end

    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        if (redirect) begin
            pc_d = word_align(target);
        end else if (grant) begin
            pc_d = pc_q + 32'd4;
        end
        // A redirect while already flushing leaves the countdown alone.
        if (discard_q != '0) begin
            if (imem_rvalid_i) discard_d = discard_q - CntW'(1);
        end else if (redirect) begin
            discard_d = stale_sum[CntW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_ADDR;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (redirect && (discard_d != '0)) state_d = StFlush;
            StFlush: if (discard_d == '0) state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    // FSM: outputs
    always_comb begin
        imem_req_o = (state_q == StRun) && (load < limit);
    end

    assign imem_addr_o = pc_q;

    assign inst_in.addr = addr_head;
    assign inst_in.data = imem_rdata_i;

    fetch_queue #(
        .Width ($bits(inst_entry_t)),
        .Depth (BUF_DEPTH)
    ) u_inst_queue (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (redirect),
        .push_i  (inst_push),
        .data_i  (inst_in),
        .pop_i   (inst_pop),
        .data_o  (inst_head),
        .count_o (occ_cnt),
        .empty_o (inst_empty)
    );

    fetch_queue #(
        .Width (XLEN),
        .Depth (BUF_DEPTH)
    ) u_addr_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (redirect),
        .push_i  (grant),
        .data_i  (pc_q),
        .pop_i   (inst_push),
        .data_o  (addr_head),
        .count_o (out_cnt),
        .empty_o (addr_empty)
    );

    assign inst_o        = inst_valid_o ? inst_head.data : NOP;
    assign inst_addr_out = inst_valid_o ? inst_head.addr : RESET_ADDR;

endmodule
